linebuf_window_ctrl: RTL and testbench

Frame sequencer for the three-row line-buffer stack that feeds 3x3 window kernels. It tracks column/row position of the incoming pixel stream, clears the line buffers between frames, and gates pixel writes into the stack. It also emits a pipelined `win_valid` with centre coordinates and frame markers aligned to the stack's `data_out_0..2`. It sits between the pixel source and the line-buffer stack; the stack's `rst_n` is driven as `~(rst | lb_clear)`.

---
 rtl/lbctrl_pkg.sv | 26 ++
 rtl/lbctrl_tag_pipe.sv | 31 +++
 rtl/linebuf_window_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_linebuf_window_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbctrl_pkg.sv
// Shared types for the line-buffer window controller: FSM states, window tag, error-counter width.
package lbctrl_pkg;

    localparam int LBCTRL_ERR_W     = 16;
    localparam int LBCTRL_TAG_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } lbctrl_state_e;

    // Coordinates are carried at a fixed width; the top keeps only its CNT_W low bits.
    typedef struct packed {
        logic                        win;
        logic [LBCTRL_TAG_CNT_W-1:0] col;
        logic [LBCTRL_TAG_CNT_W-1:0] row;
        logic                        sof;
        logic                        eol;
        logic                        eof;
    } lbctrl_tag_t;

endpackage

// File: rtl/lbctrl_tag_pipe.sv
// DEPTH-stage shift register that delays window tags to line up with the stack taps.
module lbctrl_tag_pipe
    import lbctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  lbctrl_tag_t tag_in,
    output lbctrl_tag_t tag_out
);

    lbctrl_tag_t stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/linebuf_window_ctrl.sv
// Frame sequencer for the three-row line-buffer stack: position tracking, clear, write gating, window tags.
// Defining LBCTRL_ERR_CNT_EN adds a saturating err_cnt and an err_pulse output.
module linebuf_window_ctrl
    import lbctrl_pkg::*;
#(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int CNT_W  = 7,
    parameter int LB_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             win_ready,
    output logic             lb_clear,
    output logic             lb_in_valid,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_col,
    output logic [CNT_W-1:0] win_row,
    output logic             win_sof,
    output logic             win_eol,
    output logic             win_eof,
    output logic             frame_done,
    output logic             busy
`ifdef LBCTRL_ERR_CNT_EN
    ,
    output logic [LBCTRL_ERR_W-1:0] err_cnt,
    output logic                    err_pulse
`endif
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ROW_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam int               DRAIN_W  = (LB_LAT > 1) ? $clog2(LB_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LB_LAT - 1);

    lbctrl_state_e      state_reg, state_next;
    logic [CNT_W-1:0]   col_reg, col_next;
    logic [CNT_W-1:0]   row_reg, row_next;
    logic [DRAIN_W-1:0] drain_reg, drain_next;
    logic               frame_done_reg;
    logic               accept;
    logic               col_wrap;
    logic [CNT_W-1:0]   col_m1, row_m1;
    lbctrl_tag_t        tag_in, tag_out;

    assign pix_ready   = ((state_reg == ST_PRIME) || (state_reg == ST_RUN)) && win_ready;
    assign lb_in_valid = pix_valid & pix_ready;
    // A pixel coinciding with frame_start is written but then wiped by the clear.
    assign accept      = lb_in_valid & ~frame_start;
    assign col_wrap    = (col_reg == COL_LAST);
    assign lb_clear    = (state_reg == ST_CLEAR);
    assign busy        = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        drain_next = drain_reg;
        if (frame_start) begin
            state_next = ST_CLEAR;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_CLEAR: begin
                    state_next = ST_PRIME;
                    col_next   = '0;
                    row_next   = '0;
                end
                ST_PRIME, ST_RUN: begin
                    if (accept) begin
                        col_next = col_wrap ? '0 : col_reg + 1'b1;
                        if (col_wrap) begin
                            row_next = row_reg + 1'b1;
                        end
                        if ((state_reg == ST_PRIME) && col_wrap && (row_reg == ROW_ONE)) begin
                            state_next = ST_RUN;
                        end
                        if ((state_reg == ST_RUN) && col_wrap && (row_reg == ROW_LAST)) begin
                            state_next = ST_DRAIN;
                            drain_next = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == DRAIN_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        drain_next = drain_reg + 1'b1;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            drain_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            drain_reg      <= drain_next;
            frame_done_reg <= (state_next == ST_DONE);
        end
    end

    assign col_m1 = col_reg - 1'b1;
    assign row_m1 = row_reg - 1'b1;

    // Only pixels that complete a 3x3 window carry a tag; everything else enters as a bubble.
    always_comb begin
        tag_in = '0;
        if (accept && (row_reg >= TWO) && (col_reg >= TWO)) begin
            tag_in.win = 1'b1;
            tag_in.col = LBCTRL_TAG_CNT_W'(col_m1);
            tag_in.row = LBCTRL_TAG_CNT_W'(row_m1);
            tag_in.sof = (col_reg == TWO) && (row_reg == TWO);
            tag_in.eol = col_wrap;
            tag_in.eof = col_wrap && (row_reg == ROW_LAST);
        end
    end

    lbctrl_tag_pipe #(
        .DEPTH (LB_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (frame_start),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign win_valid  = tag_out.win;
    assign win_col    = tag_out.col[CNT_W-1:0];
    assign win_row    = tag_out.row[CNT_W-1:0];
    assign win_sof    = tag_out.sof;
    assign win_eol    = tag_out.eol;
    assign win_eof    = tag_out.eof;
    assign frame_done = frame_done_reg;

    generate
        if (CNT_W < LBCTRL_TAG_CNT_W) begin : g_unused_hi
            logic unused_tag_hi;
            assign unused_tag_hi = ^{tag_out.col[LBCTRL_TAG_CNT_W-1:CNT_W],
                                     tag_out.row[LBCTRL_TAG_CNT_W-1:CNT_W]};
        end
    endgenerate

`ifdef LBCTRL_ERR_CNT_EN
    logic                    err_event;
    logic [LBCTRL_ERR_W-1:0] err_cnt_reg;
    logic                    err_pulse_reg;

    assign err_event = (frame_start && (state_reg != ST_IDLE)) ||
                       (pix_valid && ((state_reg == ST_IDLE) || (state_reg == ST_DRAIN) ||
                                      (state_reg == ST_DONE)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= err_event;
            if (err_event && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign err_cnt   = err_cnt_reg;
    assign err_pulse = err_pulse_reg;
`endif

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Self-checking bench for linebuf_window_ctrl: 8x6 frames against a pixel-order model, plus a 3x3 instance.
module tb_linebuf_window_ctrl;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int LAT   = 2;
    localparam int CW    = 7;
    localparam int NPIX  = W * H;
    localparam int RING  = 8;
    localparam int INF   = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic pix_valid = 1'b0;
    logic win_ready = 1'b1;
    logic pix_ready, lb_clear, lb_in_valid, win_valid;
    logic [CW-1:0] win_col, win_row;
    logic win_sof, win_eol, win_eof, frame_done, busy;

    logic frame_start2 = 1'b0;
    logic pix_valid2 = 1'b0;
    logic win_ready2 = 1'b1;
    logic pix_ready2, lb_clear2, lb_in_valid2, win_valid2;
    logic [1:0] win_col2, win_row2;
    logic win_sof2, win_eol2, win_eof2, frame_done2, busy2;
`ifdef LBCTRL_ERR_CNT_EN
    logic [15:0] err_cnt, err_cnt2;
    logic        err_pulse, err_pulse2;
`endif

    always #5 clk = ~clk;

    linebuf_window_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW), .LB_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .win_ready(win_ready), .lb_clear(lb_clear),
        .lb_in_valid(lb_in_valid), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .win_sof(win_sof), .win_eol(win_eol), .win_eof(win_eof),
        .frame_done(frame_done), .busy(busy)
`ifdef LBCTRL_ERR_CNT_EN
        , .err_cnt(err_cnt), .err_pulse(err_pulse)
`endif
    );

    linebuf_window_ctrl #(.IMG_W(3), .IMG_H(3), .CNT_W(2), .LB_LAT(LAT)) dut3 (
        .clk(clk), .rst(rst), .frame_start(frame_start2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .win_ready(win_ready2), .lb_clear(lb_clear2),
        .lb_in_valid(lb_in_valid2), .win_valid(win_valid2), .win_col(win_col2),
        .win_row(win_row2), .win_sof(win_sof2), .win_eol(win_eol2), .win_eof(win_eof2),
        .frame_done(frame_done2), .busy(busy2)
`ifdef LBCTRL_ERR_CNT_EN
        , .err_cnt(err_cnt2), .err_pulse(err_pulse2)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired, got timeout, expected event (cycle %0d)", name, cyc);
    endtask

    // Expected window schedule, indexed by the cycle it must appear on.
    bit r_v[RING];
    int r_col[RING], r_row[RING];
    bit r_sof[RING], r_eol[RING], r_eof[RING];

    int m_npix = 0;
    int m_active_from = INF;
    int m_clear_at = -1;
    int m_done_at = -1;
    int m_busy_from = INF;
    int m_busy_to = -1;
    int m_acc22 = -1;
    int m_err = 0;
    bit m_err_pulse = 1'b0;

    int s_wins = 0, s_eols = 0, s_eofs = 0, s_done_total = 0, s_lbv = 0, s_bad_lbv = 0;
    int s_eof_col = -1, s_eof_row = -1, s_eof_cyc = -1;
    int s_sof_col = -1, s_sof_row = -1, s_sof_cyc = -1, s_done_cyc = -1;

    always @(negedge clk) begin
        int s, k, pc, pr, sl;
        bit busy_now, exp_ready, ev;
        s = cyc % RING;
        busy_now = (cyc >= m_busy_from) && (cyc <= m_busy_to);
        exp_ready = busy_now && (cyc >= m_active_from) && (m_npix < NPIX) && win_ready;
        if (cyc >= 1) begin
            check("pix_ready", pix_ready, exp_ready);
            check("lb_in_valid", lb_in_valid, pix_valid && exp_ready);
            check("lb_clear", lb_clear, cyc == m_clear_at);
            check("busy", busy, busy_now);
            check("frame_done", frame_done, cyc == m_done_at);
            check("win_valid", win_valid, r_v[s]);
            check("win_col", win_col, r_v[s] ? r_col[s] : 0);
            check("win_row", win_row, r_v[s] ? r_row[s] : 0);
            check("win_sof", win_sof, r_v[s] && r_sof[s]);
            check("win_eol", win_eol, r_v[s] && r_eol[s]);
            check("win_eof", win_eof, r_v[s] && r_eof[s]);
`ifdef LBCTRL_ERR_CNT_EN
            check("err_cnt", err_cnt, m_err);
            check("err_pulse", err_pulse, m_err_pulse);
`endif
            if (win_valid) begin
                s_wins++;
                if (win_sof) begin s_sof_col = win_col; s_sof_row = win_row; s_sof_cyc = cyc; end
                if (win_eol) s_eols++;
                if (win_eof) begin
                    s_eofs++; s_eof_col = win_col; s_eof_row = win_row; s_eof_cyc = cyc;
                end
            end
            if (frame_done) begin s_done_total++; s_done_cyc = cyc; end
            if (lb_in_valid) s_lbv++;
            if (lb_in_valid && !pix_ready) s_bad_lbv++;
        end
        r_v[s] = 1'b0;
        if (rst) begin
            for (int i = 0; i < RING; i++) r_v[i] = 1'b0;
            m_npix = 0; m_active_from = INF; m_clear_at = -1; m_done_at = -1;
            m_busy_from = INF; m_busy_to = cyc; m_err = 0; m_err_pulse = 1'b0;
        end else begin
            ev = (frame_start && busy_now) || (pix_valid && (!busy_now || m_npix == NPIX));
            m_err_pulse = ev;
            if (ev && m_err < 65535) m_err++;
            if (frame_start) begin
                for (int i = 0; i < RING; i++) r_v[i] = 1'b0;
                m_npix = 0; m_clear_at = cyc + 1; m_active_from = cyc + 2;
                m_busy_from = cyc + 1; m_busy_to = INF; m_done_at = -1;
            end else if (pix_valid && exp_ready) begin
                k = m_npix; pc = k % W; pr = k / W;
                if (k == 2 * W + 2) m_acc22 = cyc;
                if (pr >= 2 && pc >= 2) begin
                    sl = (cyc + LAT) % RING;
                    r_v[sl] = 1'b1; r_col[sl] = pc - 1; r_row[sl] = pr - 1;
                    r_sof[sl] = (pc == 2) && (pr == 2);
                    r_eol[sl] = (pc == W - 1);
                    r_eof[sl] = (pc == W - 1) && (pr == H - 1);
                end
                m_npix++;
                if (m_npix == NPIX) begin m_done_at = cyc + LAT + 1; m_busy_to = m_done_at; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic feed(input int upto, input bit toggle, input bit hold);
        int guard;
        guard = 0;
        pix_valid = 1'b1;
        while (m_npix < upto && guard < 2000) begin
            if (toggle) win_ready = ~win_ready;
            tick();
            guard++;
        end
        if (guard >= 2000) bound_fail("feed");
        if (!hold) pix_valid = 1'b0;
        win_ready = 1'b1;
    endtask

    task automatic wait_done(input int base);
        int guard;
        guard = 0;
        while (s_done_total == base && guard < 30) begin tick(); guard++; end
        if (guard >= 30) bound_fail("frame_done_wait");
        tick();
    endtask

    int b_w, b_eol, b_eof, b_d, b_lbv, b_bad, n3, last3, wc3, dc3;
    int c3, r3, sof3, eol3, eof3, e0;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_win_valid", win_valid, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_lb_clear", lb_clear, 0);

        // continuous frame
        b_w = s_wins; b_eol = s_eols; b_eof = s_eofs; b_d = s_done_total;
        pulse_start();
        check("A_lb_clear", lb_clear, 1);
        feed(NPIX, 1'b0, 1'b0);
        wait_done(b_d);
        check("A_win_count", s_wins - b_w, 24);
        check("A_eol_count", s_eols - b_eol, 4);
        check("A_eof_count", s_eofs - b_eof, 1);
        check("A_eof_col", s_eof_col, 6);
        check("A_eof_row", s_eof_row, 4);
        check("A_sof_col", s_sof_col, 1);
        check("A_sof_row", s_sof_row, 1);
        check("A_sof_latency", s_sof_cyc - m_acc22, 2);
        check("A_done_after_eof", s_done_cyc - s_eof_cyc, 1);
        repeat (2) tick();
        check("A_idle_busy", busy, 0);

        // win_ready toggling
        b_w = s_wins; b_d = s_done_total; b_lbv = s_lbv; b_bad = s_bad_lbv;
        pulse_start();
        feed(NPIX, 1'b1, 1'b0);
        wait_done(b_d);
        check("B_win_count", s_wins - b_w, 24);
        check("B_lbv_count", s_lbv - b_lbv, 48);
        check("B_lbv_not_ready", s_bad_lbv - b_bad, 0);
        repeat (2) tick();

        // abort after 20 pixels, with a pixel offered in the abort cycle
        rst = 1'b1; tick(); rst = 1'b0; tick();
        b_d = s_done_total;
        pulse_start();
        feed(20, 1'b0, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("C_lb_clear", lb_clear, 1);
        check("C_win_flushed", win_valid, 0);
        b_w = s_wins;
        feed(NPIX, 1'b0, 1'b0);
        wait_done(b_d);
        check("C_done_count", s_done_total - b_d, 1);
        check("C_win_count", s_wins - b_w, 24);
`ifdef LBCTRL_ERR_CNT_EN
        check("C_err_cnt", err_cnt, 1);
`endif
        repeat (2) tick();

        // reset mid-RUN
        b_d = s_done_total;
        pulse_start();
        feed(30, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("D_busy", busy, 0);
        check("D_pix_ready", pix_ready, 0);
        check("D_win_valid", win_valid, 0);
        check("D_lb_in_valid", lb_in_valid, 0);
`ifdef LBCTRL_ERR_CNT_EN
        e0 = err_cnt;
`endif
        repeat (5) begin
            tick();
            check("D_idle_pix_ready", pix_ready, 0);
        end
`ifdef LBCTRL_ERR_CNT_EN
        check("D_err_idle_count", err_cnt - e0, 5);
`endif
        check("D_no_done", s_done_total - b_d, 0);

        // pix_valid held across IDLE, DRAIN and DONE
        b_d = s_done_total; b_lbv = s_lbv;
        pulse_start();
        feed(NPIX, 1'b0, 1'b1);
        repeat (8) tick();
        check("E_lbv_count", s_lbv - b_lbv, 48);
        check("E_done_count", s_done_total - b_d, 1);
        check("E_idle_pix_ready", pix_ready, 0);
        pix_valid = 1'b0;
        tick();

        // 3x3 frame on the second instance
        frame_start2 = 1'b1;
        tick();
        frame_start2 = 1'b0;
        check("F_lb_clear", lb_clear2, 1);
        pix_valid2 = 1'b1;
        n3 = 0; last3 = -1;
        for (int i = 0; i < 40 && n3 < 9; i++) begin
            if (lb_in_valid2) begin n3++; last3 = cyc; end
            if (n3 < 9) tick();
        end
        tick();
        pix_valid2 = 1'b0;
        check("F_accept_count", n3, 9);
        b_w = 0; wc3 = -1; dc3 = -1; c3 = -1; r3 = -1; sof3 = 0; eol3 = 0; eof3 = 0;
        for (int i = 0; i < 10; i++) begin
            if (win_valid2) begin
                b_w++; wc3 = cyc; c3 = win_col2; r3 = win_row2;
                sof3 = win_sof2; eol3 = win_eol2; eof3 = win_eof2;
            end
            if (frame_done2) dc3 = cyc;
            tick();
        end
        check("F_win_count", b_w, 1);
        check("F_win_col", c3, 1);
        check("F_win_row", r3, 1);
        check("F_flags", {sof3[0], eol3[0], eof3[0]}, 3'b111);
        check("F_win_latency", wc3 - last3, 2);
        check("F_done_after_win", dc3 - wc3, 1);
        check("F_idle_busy", busy2, 0);
        check("F_ready_idle", pix_ready2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
